// File: rtl/edge_window.sv
// Gates a downstream edge logger for a fixed window of oscillator edges once lock has settled.
// Outputs are registered: one edge from a decision to its effect; lock adds two edges of synchronizer delay.
module edge_window #(
  parameter int WIDTH         = 32,
  parameter int SKIP_EDGES    = 1024,
  parameter int CAPTURE_EDGES = 4096
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             lock,
  input  logic             abort,
  output logic             enable,
  output logic             done,
  output logic             busy,
  output logic             lock_err,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, SKIP, CAPTURE, DONE} state_t;

  localparam logic [WIDTH-1:0] SKIP_LAST = WIDTH'((SKIP_EDGES > 0) ? SKIP_EDGES - 1 : 0);
  localparam logic [WIDTH-1:0] CAP_LAST  = WIDTH'(CAPTURE_EDGES - 1);

  state_t           state;
  logic [WIDTH-1:0] skip_cnt;
  logic             lock_m;
  logic             lock_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  // enable/busy/done are set alongside each transition so they stay glitch-free flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      enable   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      lock_err <= 1'b0;
      count    <= '0;
      skip_cnt <= '0;
    end else if (abort) begin
      state  <= IDLE;
      enable <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WAIT_LOCK;
            busy     <= 1'b1;
            done     <= 1'b0;
            count    <= '0;
            lock_err <= 1'b0;
            skip_cnt <= '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            skip_cnt <= '0;
            if (SKIP_EDGES == 0) begin
              state  <= CAPTURE;
              enable <= 1'b1;
            end else begin
              state <= SKIP;
            end
          end
        end
        SKIP: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            skip_cnt <= '0;
          end else if (skip_cnt == SKIP_LAST) begin
            state  <= CAPTURE;
            enable <= 1'b1;
          end else begin
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!lock_s) begin
            // Lock lost: close the window early and keep the partial count.
            state    <= DONE;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            lock_err <= 1'b1;
          end else begin
            if (count != '1) begin
              count <= count + 1'b1;
            end
            if (count == CAP_LAST) begin
              state  <= DONE;
              enable <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
